// File: rtl/running_bounded_integrator.sv
// Sliding-window sum over the last m accepted samples, updated recursively
// from a circular buffer; m is latched on clear and clamped to 1..MAX_SIZE.
module running_bounded_integrator #(
  parameter int WIDTH    = 16,
  parameter int MAX_SIZE = 17,
  parameter int SWIDTH   = $clog2(MAX_SIZE + 1),
  parameter int OWIDTH   = WIDTH + $clog2(MAX_SIZE + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [SWIDTH-1:0] size,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [OWIDTH-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic              o_tuser
);

  localparam logic [SWIDTH-1:0] MAX_M = SWIDTH'(MAX_SIZE);

  logic [SWIDTH-1:0] r_m;
  logic [SWIDTH-1:0] r_wr_ptr;
  logic [SWIDTH-1:0] r_count;
  logic [OWIDTH-1:0] r_acc;
  logic              r_o_tvalid;
  logic              r_o_tuser;
  logic              r_run;
  logic [WIDTH-1:0]  r_buf [MAX_SIZE];

  logic              w_accept;
  logic              w_full;
  logic [WIDTH-1:0]  w_old;
  logic [OWIDTH-1:0] w_x_ext;
  logic [OWIDTH-1:0] w_old_ext;
  logic [OWIDTH-1:0] w_acc_next;
  logic [SWIDTH-1:0] w_size_clamped;
  logic [SWIDTH-1:0] w_ptr_next;
  logic [SWIDTH-1:0] w_count_next;

  // r_run keeps i_tready low while reset is held and until the first edge after release.
  assign i_tready  = r_run & ~clear & (~r_o_tvalid | o_tready);
  assign w_accept  = i_tvalid & i_tready;
  assign w_full    = (r_count == r_m);
  assign w_old     = r_buf[r_wr_ptr];
  assign w_x_ext   = {{(OWIDTH-WIDTH){i_tdata[WIDTH-1]}}, i_tdata};
  assign w_old_ext = {{(OWIDTH-WIDTH){w_old[WIDTH-1]}}, w_old};

  assign o_tdata  = r_acc;
  assign o_tvalid = r_o_tvalid;
  assign o_tuser  = r_o_tuser;

  always_comb begin
    w_size_clamped = size;
    if (size == '0) begin
      w_size_clamped = SWIDTH'(1);
    end else if (size > MAX_M) begin
      w_size_clamped = MAX_M;
    end
  end

  // Until the window has filled, the slot being overwritten holds stale data and is not subtracted.
  always_comb begin
    w_ptr_next   = (r_wr_ptr == r_m - SWIDTH'(1)) ? '0 : r_wr_ptr + SWIDTH'(1);
    w_count_next = w_full ? r_count : r_count + SWIDTH'(1);
    w_acc_next   = w_full ? (r_acc + w_x_ext - w_old_ext) : (r_acc + w_x_ext);
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= i_tdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m        <= MAX_M;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_acc      <= '0;
      r_o_tvalid <= 1'b0;
      r_o_tuser  <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (clear) begin
        r_m        <= w_size_clamped;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_acc      <= '0;
        r_o_tvalid <= 1'b0;
        r_o_tuser  <= 1'b0;
      end else if (w_accept) begin
        r_wr_ptr   <= w_ptr_next;
        r_count    <= w_count_next;
        r_acc      <= w_acc_next;
        r_o_tvalid <= 1'b1;
        r_o_tuser  <= (w_count_next == r_m);
      end else if (o_tready) begin
        r_o_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_running_bounded_integrator.sv
// Bench for running_bounded_integrator: directed sequences with literal results,
// then random traffic checked every cycle against a window-sum model.
module tb_running_bounded_integrator;

  localparam int WIDTH    = 16;
  localparam int MAX_SIZE = 17;
  localparam int SWIDTH   = $clog2(MAX_SIZE + 1);
  localparam int OWIDTH   = WIDTH + $clog2(MAX_SIZE + 1);

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clear;
  logic [SWIDTH-1:0] size;
  logic [WIDTH-1:0]  i_tdata;
  logic              i_tvalid;
  logic              i_tready;
  logic [OWIDTH-1:0] o_tdata;
  logic              o_tvalid;
  logic              o_tready;
  logic              o_tuser;

  running_bounded_integrator #(
    .WIDTH(WIDTH), .MAX_SIZE(MAX_SIZE), .SWIDTH(SWIDTH), .OWIDTH(OWIDTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .size(size),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tuser(o_tuser)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: history of accepted samples since reset/clear, latched window length.
  int win[$];
  int cnt;
  int m_mod;
  bit rdy_mod;
  bit ev;
  int ed;
  bit eu;
  bit exp_rdy;
  int dsv;
  int k;
  int s;

  int got[$];
  bit gotu[$];
  int exp_q[$];
  bit exp_u[$];

  function automatic int clampm(input int sz);
    if (sz == 0) return 1;
    if (sz > MAX_SIZE) return MAX_SIZE;
    return sz;
  endfunction

  task automatic model_reset();
    win.delete();
    cnt     = 0;
    m_mod   = MAX_SIZE;
    rdy_mod = 0;
    ev      = 0;
  endtask

  always @(negedge reset_n) model_reset();

  always @(negedge clk) begin
    if (!reset_n) begin
      total++;
      if (o_tvalid !== 1'b0 || o_tdata !== '0 || o_tuser !== 1'b0 || i_tready !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: valid=%b data=%0h user=%b ready=%b, want all 0", o_tvalid, o_tdata, o_tuser, i_tready);
      end
      model_reset();
    end else begin
      exp_rdy = rdy_mod && !clear && (!ev || o_tready);
      total++;
      if (i_tready !== exp_rdy) begin
        bad++;
        $display("FAIL i_tready: got %b want %b", i_tready, exp_rdy);
      end
      total++;
      if (o_tvalid !== ev) begin
        bad++;
        $display("FAIL o_tvalid: got %b want %b", o_tvalid, ev);
      end
      if (ev) begin
        dsv = $signed(o_tdata);
        total++;
        if (dsv != ed) begin
          bad++;
          $display("FAIL o_tdata: got %0d want %0d", dsv, ed);
        end
        total++;
        if (o_tuser !== eu) begin
          bad++;
          $display("FAIL o_tuser: got %b want %b", o_tuser, eu);
        end
        if (o_tready && !clear) begin
          got.push_back(dsv);
          gotu.push_back(o_tuser);
        end
      end
      // Advance the model to the state after the coming edge.
      if (clear) begin
        win.delete();
        cnt   = 0;
        m_mod = clampm(int'(size));
        ev    = 0;
      end else if (i_tvalid && exp_rdy) begin
        win.push_back(int'($signed(i_tdata)));
        if (win.size() > MAX_SIZE) void'(win.pop_front());
        cnt++;
        k = (cnt < m_mod) ? cnt : m_mod;
        s = 0;
        for (int i = 0; i < k; i++) s += win[win.size() - 1 - i];
        ed = s;
        eu = (cnt >= m_mod);
        ev = 1;
      end else if (o_tready) begin
        ev = 0;
      end
      rdy_mod = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input int sz, input bit v, input int d);
    clear    = 1'b1;
    size     = SWIDTH'(sz);
    i_tvalid = v;
    i_tdata  = WIDTH'(d);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
  endtask

  task automatic send(input int x);
    bit ok;
    ok       = 0;
    i_tvalid = 1'b1;
    i_tdata  = WIDTH'(x);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (i_tready) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: sample %0d not accepted within 100 cycles", x);
    end
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
  endtask

  task automatic check_got(input string name);
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_count: got %0d outputs want %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] != exp_q[i]) begin
        bad++;
        $display("FAIL %s[%0d]: got %0d want %0d", name, i, (i < got.size()) ? got[i] : 32'hDEAD, exp_q[i]);
      end
    end
  endtask

  task automatic check_user(input string name);
    for (int i = 0; i < exp_u.size(); i++) begin
      total++;
      if (i >= gotu.size() || gotu[i] != exp_u[i]) begin
        bad++;
        $display("FAIL %s[%0d]: got %b want %b", name, i, (i < gotu.size()) ? gotu[i] : 1'bx, exp_u[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    size     = '0;
    i_tdata  = '0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Window of 4, ramp input.
    do_clear(4, 0, 0);
    got.delete(); gotu.delete();
    for (int v = 1; v <= 6; v++) send(v);
    idle(4);
    exp_q = '{1, 3, 6, 10, 14, 18};
    check_got("ramp_m4");
    exp_u = '{0, 0, 0, 1, 1, 1};
    check_user("ramp_m4_user");

    // Most negative samples, window of 3.
    do_clear(3, 0, 0);
    got.delete(); gotu.delete();
    repeat (5) send(-32768);
    idle(4);
    exp_q = '{-32768, -65536, -98304, -98304, -98304};
    check_got("neg_m3");

    // Output stall: data held, input refused, stream intact afterwards.
    do_clear(4, 0, 0);
    got.delete(); gotu.delete();
    o_tready = 1'b0;
    send(1);
    i_tvalid = 1'b1;
    i_tdata  = WIDTH'(2);
    repeat (3) begin
      @(negedge clk);
      total++;
      if ($signed(o_tdata) != 1 || i_tready !== 1'b0 || o_tvalid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold: data=%0d ready=%b valid=%b, want 1/0/1", $signed(o_tdata), i_tready, o_tvalid);
      end
    end
    @(posedge clk);
    #1;
    o_tready = 1'b1;
    for (int v = 2; v <= 5; v++) send(v);
    idle(4);
    exp_q = '{1, 3, 6, 10, 14};
    check_got("stall");

    // Clear mid-stream with a valid input in the clear cycle.
    do_clear(4, 0, 0);
    send(1); send(2); send(3);
    idle(2);
    do_clear(2, 1, 100);
    got.delete(); gotu.delete();
    send(7); send(8); send(9);
    idle(4);
    exp_q = '{7, 15, 17};
    check_got("clear_mid");

    // Asynchronous reset mid-stream.
    do_clear(4, 0, 0);
    send(1); send(2);
    i_tvalid = 1'b1;
    i_tdata  = WIDTH'(3);
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (o_tvalid !== 1'b0 || o_tdata !== '0 || o_tuser !== 1'b0 || i_tready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: valid=%b data=%0h user=%b ready=%b, want all 0", o_tvalid, o_tdata, o_tuser, i_tready);
    end
    i_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    got.delete(); gotu.delete();
    repeat (19) send(1);
    idle(4);
    exp_q.delete(); exp_u.delete();
    for (int i = 1; i <= 19; i++) begin
      exp_q.push_back((i < 17) ? i : 17);
      exp_u.push_back(i >= 17);
    end
    check_got("after_reset");
    check_user("after_reset_user");

    // Size clamping at both ends.
    do_clear(0, 0, 0);
    got.delete(); gotu.delete();
    send(5); send(-3);
    idle(4);
    exp_q = '{5, -3};
    check_got("size0");
    do_clear(20, 0, 0);
    got.delete(); gotu.delete();
    repeat (20) send(1);
    idle(4);
    exp_q.delete();
    for (int i = 1; i <= 20; i++) exp_q.push_back((i < 17) ? i : 17);
    check_got("size20");

    // Random traffic, checked cycle by cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      clear    = ($urandom_range(0, 39) == 0);
      size     = SWIDTH'($urandom_range(0, 20));
      i_tvalid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       i_tdata = 16'h8000;
        1:       i_tdata = 16'h7FFF;
        default: i_tdata = WIDTH'($urandom);
      endcase
      o_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    clear    = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
